hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 31 +++
 rtl/mdu_stall_ctr.sv | 84 ++++++++
 rtl/hazard_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared constants and state types for the hazard/pipeline-control unit
//
// Contents:
//   FWD_RF / FWD_W / FWD_M : forward-select encodings (00 regfile, 01 from W, 10 from M)
//   mdu_state_t            : multiply/divide stall FSM states
//   mem_state_t            : data-memory wait FSM states
//   ctr_width()            : counter width able to hold values 0..max_val (at least 1 bit)
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    typedef enum logic {
        MIDLE = 1'b0,
        MWAIT = 1'b1
    } mem_state_t;

    function automatic int ctr_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mdu_stall_ctr.sv
// rtl/mdu_stall_ctr.sv - multiply/divide stall FSM with internal latency counter
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : exception flush; returns the FSM to IDLE and suppresses any done pulse
//   md_startE  : mul/div instruction present in E (only sampled in IDLE)
//   md_divE    : 1 = divide, 0 = multiply; selects the latency loaded at start
//   md_stall   : combinational hold request for the front of the pipe
//   md_doneE   : registered, high for the single cycle the FSM sits in DONE
module mdu_stall_ctr
    import hazard_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 34
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic md_startE,
    input  logic md_divE,
    output logic md_stall,
    output logic md_doneE
);

    localparam int MAX_LOAD = ((DIV_CYCLES > MUL_CYCLES) ? DIV_CYCLES : MUL_CYCLES) - 1;
    localparam int CNT_W    = ctr_width(MAX_LOAD);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             md_done_q, md_done_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (md_startE) begin
                    state_d = BUSY;
                    cnt_d   = md_divE ? DIV_LOAD : MUL_LOAD;
                end
            end
            BUSY: begin
                // Leave BUSY once the decremented count hits zero, so the start
                // cycle plus BUSY span exactly the latency. A load of zero
                // (latency 1) saturates and still spends one cycle in BUSY.
                cnt_d = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
                if (cnt_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Exception wins over everything, including a start in the same cycle.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        md_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            md_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            md_done_q <= md_done_d;
        end
    end

    assign md_stall = ((state_q == IDLE) && md_startE) || (state_q == BUSY);
    assign md_doneE = md_done_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - hazard detection, forwarding and stall/flush control for the 5-stage core
//
// Build option: HAZARD_CP0_FWD_EN enables CP0 read forwarding (forwardcp0E); when
// undefined forwardcp0E is tied to 00 and rdE/rdM/rdW/cp0readE/cp0weM/cp0weW are unused.
//
// Ports:
//   clk, rst                      : clock, asynchronous active-high reset
//   rsD, rtD, branchD/jumpD/jrD   : decode-stage sources and control-flow flags
//   rsE, rtE, rdE, writeregE, ... : execute-stage fields/controls, mul/div start and type
//   writeregM, rdM, ...           : memory-stage fields/controls, data-memory req/ack
//   writeregW, rdW, ...           : writeback-stage fields/controls
//   except_validM                 : exception in M; flushes all stages, masks all stalls
//   stall*/flush*                 : per-stage hold and clear
//   forward*                      : forward selects (00 regfile, 10 from M, 01 from W)
//   lwstallD, branchstallD        : raw stall causes for debug
//   md_doneE, mem_timeout         : registered single-cycle pulses
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int RA_W        = 5,
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 34,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] rsD,
    input  logic [RA_W-1:0] rtD,
    input  logic            branchD,
    input  logic            jumpD,
    input  logic            jrD,
    input  logic [RA_W-1:0] rsE,
    input  logic [RA_W-1:0] rtE,
    input  logic [RA_W-1:0] rdE,
    input  logic [RA_W-1:0] writeregE,
    input  logic            regwriteE,
    input  logic            memtoregE,
    input  logic            cp0readE,
    input  logic            md_startE,
    input  logic            md_divE,
    input  logic [RA_W-1:0] writeregM,
    input  logic [RA_W-1:0] rdM,
    input  logic            regwriteM,
    input  logic            memtoregM,
    input  logic            hlwriteM,
    input  logic            cp0weM,
    input  logic            mem_reqM,
    input  logic            mem_ackM,
    input  logic [RA_W-1:0] writeregW,
    input  logic [RA_W-1:0] rdW,
    input  logic            regwriteW,
    input  logic            cp0weW,
    input  logic            except_validM,
    output logic            stallF,
    output logic            stallD,
    output logic            stallE,
    output logic            stallM,
    output logic            stallW,
    output logic            flushF,
    output logic            flushD,
    output logic            flushE,
    output logic            flushM,
    output logic            flushW,
    output logic            forwardaD,
    output logic            forwardbD,
    output logic [1:0]      forwardaE,
    output logic [1:0]      forwardbE,
    output logic [1:0]      forwardcp0E,
    output logic            forwardhlE,
    output logic            lwstallD,
    output logic            branchstallD,
    output logic            md_doneE,
    output logic            mem_timeout
);

    localparam int MCNT_W = ctr_width(MEM_TIMEOUT - 1);
    localparam logic [MCNT_W-1:0] MEM_LAST = MCNT_W'(MEM_TIMEOUT - 1);

    logic md_stall;
    logic mem_stall;

    // ---------------- forwarding ----------------
    assign forwardaD  = (rsD != '0) && (rsD == writeregM) && regwriteM;
    assign forwardbD  = (rtD != '0) && (rtD == writeregM) && regwriteM;
    assign forwardhlE = hlwriteM;

    always_comb begin
        forwardaE = FWD_RF;
        if ((rsE != '0) && (rsE == writeregM) && regwriteM) begin
            forwardaE = FWD_M;
        end else if ((rsE != '0) && (rsE == writeregW) && regwriteW) begin
            forwardaE = FWD_W;
        end
        forwardbE = FWD_RF;
        if ((rtE != '0) && (rtE == writeregM) && regwriteM) begin
            forwardbE = FWD_M;
        end else if ((rtE != '0) && (rtE == writeregW) && regwriteW) begin
            forwardbE = FWD_W;
        end
    end

`ifdef HAZARD_CP0_FWD_EN
    // CP0 register 0 is a real register, so no zero-index exclusion here.
    always_comb begin
        forwardcp0E = FWD_RF;
        if (cp0readE) begin
            if ((rdM == rdE) && cp0weM) begin
                forwardcp0E = FWD_M;
            end else if ((rdW == rdE) && cp0weW) begin
                forwardcp0E = FWD_W;
            end
        end
    end
`else
    assign forwardcp0E = FWD_RF;
    logic unused_cp0;
    assign unused_cp0 = ^{cp0readE, rdE, rdM, rdW, cp0weM, cp0weW};
`endif

    // ---------------- decode-stage hazards ----------------
    assign lwstallD = memtoregE && ((rtE == rsD) || (rtE == rtD));
    assign branchstallD = (branchD || (jumpD && jrD)) &&
                          ((regwriteE && ((writeregE == rsD) || (writeregE == rtD))) ||
                           (memtoregM && ((writeregM == rsD) || (writeregM == rtD))));

    // ---------------- multiply/divide stall ----------------
    mdu_stall_ctr #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_mdu (
        .clk       (clk),
        .rst       (rst),
        .flush     (except_validM),
        .md_startE (md_startE),
        .md_divE   (md_divE),
        .md_stall  (md_stall),
        .md_doneE  (md_doneE)
    );

    // ---------------- data-memory wait / timeout ----------------
    mem_state_t        mem_state_q, mem_state_d;
    logic [MCNT_W-1:0] mem_cnt_q, mem_cnt_d;
    logic              mem_timeout_q, mem_timeout_d;

    always_comb begin
        mem_state_d   = mem_state_q;
        mem_cnt_d     = mem_cnt_q;
        mem_timeout_d = 1'b0;
        case (mem_state_q)
            MIDLE: begin
                if (mem_reqM && !mem_ackM) begin
                    mem_state_d = MWAIT;
                    mem_cnt_d   = '0;
                end
            end
            MWAIT: begin
                // An ack arriving with the final count wins: no timeout pulse.
                if (mem_ackM) begin
                    mem_state_d = MIDLE;
                    mem_cnt_d   = '0;
                end else begin
                    mem_cnt_d = mem_cnt_q + MCNT_W'(1);
                    if (mem_cnt_d == MEM_LAST) begin
                        mem_state_d   = MIDLE;
                        mem_cnt_d     = '0;
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                mem_state_d = MIDLE;
                mem_cnt_d   = '0;
            end
        endcase
        if (except_validM) begin
            mem_state_d   = MIDLE;
            mem_cnt_d     = '0;
            mem_timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_state_q   <= MIDLE;
            mem_cnt_q     <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            mem_state_q   <= mem_state_d;
            mem_cnt_q     <= mem_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // The timeout cycle releases the pipe even though the request is still up.
    assign mem_stall   = mem_reqM && !mem_ackM && !mem_timeout_q;
    assign mem_timeout = mem_timeout_q;

    // ---------------- stall / flush ----------------
    assign stallD = !except_validM && (lwstallD || branchstallD || md_stall || mem_stall);
    assign stallF = stallD;
    assign stallE = !except_validM && (md_stall || mem_stall);
    assign stallM = !except_validM && mem_stall;
    assign stallW = stallM;

    assign flushF = except_validM;
    assign flushD = except_validM;
    assign flushM = except_validM;
    assign flushW = except_validM;
    // E gets a bubble when D is held (or a jump leaves), unless E itself is held.
    assign flushE = except_validM || ((lwstallD || branchstallD || jumpD) && !stallE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a cycle-count reference model
module tb_hazard_ctrl;

    localparam int MUL_N = 4;
    localparam int DIV_N = 34;
    localparam int MEM_T = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rsD, rtD, rsE, rtE, rdE, writeregE, writeregM, rdM, writeregW, rdW;
    logic       branchD, jumpD, jrD, regwriteE, memtoregE, cp0readE, md_startE, md_divE;
    logic       regwriteM, memtoregM, hlwriteM, cp0weM, mem_reqM, mem_ackM;
    logic       regwriteW, cp0weW, except_validM;
    logic       stallF, stallD, stallE, stallM, stallW;
    logic       flushF, flushD, flushE, flushM, flushW;
    logic       forwardaD, forwardbD, forwardhlE, lwstallD, branchstallD, md_doneE, mem_timeout;
    logic [1:0] forwardaE, forwardbE, forwardcp0E;

    int checks = 0;
    int errors = 0;

    // reference model: remaining mul/div busy cycles, pending done, cycles stalled on memory
    int m_md_left;
    bit m_md_done;
    int m_mem_cnt;
    bit m_to;

    int obs_stallE, obs_stallM, obs_done, obs_to;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .RA_W(5), .MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N), .MEM_TIMEOUT(MEM_T)
    ) dut (
        .clk(clk), .rst(rst),
        .rsD(rsD), .rtD(rtD), .branchD(branchD), .jumpD(jumpD), .jrD(jrD),
        .rsE(rsE), .rtE(rtE), .rdE(rdE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE), .cp0readE(cp0readE),
        .md_startE(md_startE), .md_divE(md_divE),
        .writeregM(writeregM), .rdM(rdM), .regwriteM(regwriteM), .memtoregM(memtoregM),
        .hlwriteM(hlwriteM), .cp0weM(cp0weM), .mem_reqM(mem_reqM), .mem_ackM(mem_ackM),
        .writeregW(writeregW), .rdW(rdW), .regwriteW(regwriteW), .cp0weW(cp0weW),
        .except_validM(except_validM),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE), .forwardcp0E(forwardcp0E),
        .forwardhlE(forwardhlE), .lwstallD(lwstallD), .branchstallD(branchstallD),
        .md_doneE(md_doneE), .mem_timeout(mem_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        {rsD, rtD, rsE, rtE, rdE, writeregE, writeregM, rdM, writeregW, rdW} = '0;
        {branchD, jumpD, jrD, regwriteE, memtoregE, cp0readE, md_startE, md_divE} = '0;
        {regwriteM, memtoregM, hlwriteM, cp0weM, mem_reqM, mem_ackM} = '0;
        {regwriteW, cp0weW, except_validM} = '0;
    endtask

    task automatic model_reset();
        m_md_left = 0;
        m_md_done = 1'b0;
        m_mem_cnt = 0;
        m_to      = 1'b0;
    endtask

    task automatic clear_obs();
        obs_stallE = 0;
        obs_stallM = 0;
        obs_done   = 0;
        obs_to     = 0;
    endtask

    function automatic logic [1:0] exp_fwd_e(input logic [4:0] src);
        if (src == 5'd0) return 2'b00;
        if (regwriteM && src == writeregM) return 2'b10;
        if (regwriteW && src == writeregW) return 2'b01;
        return 2'b00;
    endfunction

    // Checks every output mid-cycle against the model, then advances one clock.
    task automatic step();
        logic lw, br, mds, mems, ex, st_d, st_e, st_m;
        logic [1:0] fc;
        int lat;
        #4;
        ex   = except_validM;
        lw   = memtoregE && (rtE == rsD || rtE == rtD);
        br   = (branchD || (jumpD && jrD)) &&
               ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                (memtoregM && (writeregM == rsD || writeregM == rtD)));
        mds  = (m_md_left > 0) || (!m_md_done && md_startE);
        mems = mem_reqM && !mem_ackM && !m_to;
        st_d = !ex && (lw || br || mds || mems);
        st_e = !ex && (mds || mems);
        st_m = !ex && mems;
        fc   = 2'b00;
`ifdef HAZARD_CP0_FWD_EN
        if (cp0readE) fc = (cp0weM && rdM == rdE) ? 2'b10 : (cp0weW && rdW == rdE) ? 2'b01 : 2'b00;
`endif
        chk("stallF", stallF, st_d);
        chk("stallD", stallD, st_d);
        chk("stallE", stallE, st_e);
        chk("stallM", stallM, st_m);
        chk("stallW", stallW, st_m);
        chk("flushF", flushF, ex);
        chk("flushD", flushD, ex);
        chk("flushE", flushE, ex || ((lw || br || jumpD) && !st_e));
        chk("flushM", flushM, ex);
        chk("flushW", flushW, ex);
        chk("forwardaD", forwardaD, rsD != 0 && rsD == writeregM && regwriteM);
        chk("forwardbD", forwardbD, rtD != 0 && rtD == writeregM && regwriteM);
        chk("forwardaE", forwardaE, exp_fwd_e(rsE));
        chk("forwardbE", forwardbE, exp_fwd_e(rtE));
        chk("forwardcp0E", forwardcp0E, fc);
        chk("forwardhlE", forwardhlE, hlwriteM);
        chk("lwstallD", lwstallD, lw);
        chk("branchstallD", branchstallD, br);
        chk("md_doneE", md_doneE, m_md_done);
        chk("mem_timeout", mem_timeout, m_to);
        if (stallE === 1'b1) obs_stallE++;
        if (stallM === 1'b1) obs_stallM++;
        if (md_doneE === 1'b1) obs_done++;
        if (mem_timeout === 1'b1) obs_to++;

        lat = md_divE ? DIV_N : MUL_N;
        if (rst || ex) begin
            m_md_left = 0;
            m_md_done = 1'b0;
        end else if (m_md_left > 0) begin
            m_md_left--;
            m_md_done = (m_md_left == 0);
        end else if (!m_md_done && md_startE) begin
            // total hold = latency cycles (start cycle included); latency 1 still gets one busy cycle
            m_md_left = (lat > 1) ? lat - 1 : 1;
        end else begin
            m_md_done = 1'b0;
        end

        if (rst || ex) begin
            m_mem_cnt = 0;
            m_to      = 1'b0;
        end else if (m_mem_cnt > 0) begin
            m_to = 1'b0;
            if (mem_ackM) begin
                m_mem_cnt = 0;
            end else if (m_mem_cnt + 1 == MEM_T) begin
                m_mem_cnt = 0;
                m_to      = 1'b1;
            end else begin
                m_mem_cnt++;
            end
        end else begin
            m_to = 1'b0;
            if (mem_reqM && !mem_ackM) m_mem_cnt = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        model_reset();
        clear_obs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        step();

        // E forwarding: M beats W; register 0 never forwards
        rsE = 5'd3; writeregM = 5'd3; regwriteM = 1'b1; writeregW = 5'd3; regwriteW = 1'b1;
        #2 chk("tp_fwdaE_M", forwardaE, 2'b10);
        step();
        rsE = 5'd0;
        #2 chk("tp_fwdaE_zero", forwardaE, 2'b00);
        step();
        clear_inputs();

        // load-use
        memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
        #2;
        chk("tp_lw_lwstallD", lwstallD, 1'b1);
        chk("tp_lw_stallD", stallD, 1'b1);
        chk("tp_lw_stallE", stallE, 1'b0);
        chk("tp_lw_flushE", flushE, 1'b1);
        step();
        clear_inputs();
        step();

        // branch waiting on an E-stage writer
        branchD = 1'b1; rsD = 5'd7; regwriteE = 1'b1; writeregE = 5'd7;
        #2 chk("tp_branchstall", branchstallD, 1'b1);
        step();
        clear_inputs();

        // divide then multiply latency
        clear_obs();
        md_startE = 1'b1; md_divE = 1'b1;
        step();
        md_startE = 1'b0;
        repeat (DIV_N + 4) step();
        chk("tp_div_stall_cycles", obs_stallE, DIV_N);
        chk("tp_div_done_pulses", obs_done, 1);
        clear_obs();
        md_startE = 1'b1; md_divE = 1'b0;
        step();
        md_startE = 1'b0;
        repeat (MUL_N + 4) step();
        chk("tp_mul_stall_cycles", obs_stallE, MUL_N);
        chk("tp_mul_done_pulses", obs_done, 1);

        // memory timeout, then ack on the third cycle
        clear_obs();
        mem_reqM = 1'b1;
        repeat (MEM_T + 1) step();
        chk("tp_mem_stall_cycles", obs_stallM, MEM_T);
        chk("tp_mem_timeout_pulses", obs_to, 1);
        mem_reqM = 1'b0; mem_ackM = 1'b1;
        step();
        mem_ackM = 1'b0;
        step();
        clear_obs();
        mem_reqM = 1'b1;
        step();
        step();
        mem_ackM = 1'b1;
        step();
        mem_reqM = 1'b0; mem_ackM = 1'b0;
        repeat (MEM_T + 2) step();
        chk("tp_mem_ack_stalls", obs_stallM, 2);
        chk("tp_mem_ack_no_pulse", obs_to, 0);

        // exception during a busy multiply
        md_startE = 1'b1;
        step();
        md_startE = 1'b0;
        step();
        except_validM = 1'b1; mem_reqM = 1'b1;
        #2;
        chk("tp_exc_flush", {flushF, flushD, flushE, flushM, flushW}, 5'b11111);
        chk("tp_exc_stall", {stallF, stallD, stallE, stallM, stallW}, 5'b00000);
        step();
        except_validM = 1'b0; mem_reqM = 1'b0;
        clear_obs();
        repeat (MUL_N + 3) step();
        chk("tp_exc_no_done", obs_done, 0);

        // asynchronous reset in the middle of a divide
        md_startE = 1'b1; md_divE = 1'b1;
        step();
        md_startE = 1'b0; md_divE = 1'b0;
        repeat (5) step();
        #2 rst = 1'b1;
        model_reset();
        step();
        rst = 1'b0;
        clear_obs();
        repeat (DIV_N + 4) step();
        chk("tp_rst_no_done", obs_done, 0);
        chk("tp_rst_no_stall", obs_stallE, 0);

        // CP0 forward (tied off when the option is not built)
        cp0readE = 1'b1; rdE = 5'd12; rdM = 5'd12; cp0weM = 1'b1;
`ifdef HAZARD_CP0_FWD_EN
        #2 chk("tp_cp0_fwd_M", forwardcp0E, 2'b10);
`else
        #2 chk("tp_cp0_tied", forwardcp0E, 2'b00);
`endif
        step();
        clear_inputs();

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            rsD = 5'($urandom_range(0, 3));       rtD = 5'($urandom_range(0, 3));
            rsE = 5'($urandom_range(0, 3));       rtE = 5'($urandom_range(0, 3));
            rdE = 5'($urandom_range(0, 3));       writeregE = 5'($urandom_range(0, 3));
            writeregM = 5'($urandom_range(0, 3)); rdM = 5'($urandom_range(0, 3));
            writeregW = 5'($urandom_range(0, 3)); rdW = 5'($urandom_range(0, 3));
            branchD   = ($urandom_range(0, 3) == 0);
            jumpD     = ($urandom_range(0, 5) == 0);
            jrD       = $urandom_range(0, 1) == 1;
            regwriteE = $urandom_range(0, 1) == 1;
            memtoregE = ($urandom_range(0, 3) == 0);
            cp0readE  = $urandom_range(0, 1) == 1;
            md_startE = ($urandom_range(0, 7) == 0);
            md_divE   = ($urandom_range(0, 3) == 0);
            regwriteM = $urandom_range(0, 1) == 1;
            memtoregM = ($urandom_range(0, 3) == 0);
            hlwriteM  = $urandom_range(0, 1) == 1;
            cp0weM    = $urandom_range(0, 1) == 1;
            mem_reqM  = ($urandom_range(0, 2) == 0);
            mem_ackM  = ($urandom_range(0, 4) == 0);
            regwriteW = $urandom_range(0, 1) == 1;
            cp0weW    = $urandom_range(0, 1) == 1;
            except_validM = ($urandom_range(0, 24) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
